mem_port_arbiter: RTL and testbench

//  Shares one memory port between the pipeline's three cache-side requesters: icache fetch, dcache read, dcache write.
//  - Latches one-cycle request pulses, arbitrates between them and issues one transaction at a time.
//  - Routes the memory's done/data back to the owner.
//  - Sits between the pipeline top and the memory/bus model.
//  - Implementation: 2-state FSM plus per-requester pending registers.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signal bundle for mem_port_arbiter.
// master = the arbiter; slave = requesters plus memory model.
interface mem_port_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          icache_rqst;
    logic [AW-1:0] icache_addr;
    logic          icache_done;
    logic [DW-1:0] icache_data;

    logic          dr_rqst;
    logic [AW-1:0] dr_addr;
    logic [2:0]    dr_bits;
    logic          dr_done;
    logic [DW-1:0] dr_data;

    logic          dw_rqst;
    logic [AW-1:0] dw_addr;
    logic [2:0]    dw_bits;
    logic [DW-1:0] dw_data;
    logic          dw_done;

    logic          mem_rqst;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_bits;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  icache_rqst, icache_addr,
        input  dr_rqst, dr_addr, dr_bits,
        input  dw_rqst, dw_addr, dw_bits, dw_data,
        input  mem_done, mem_rdata,
        output icache_done, icache_data,
        output dr_done, dr_data, dw_done,
        output mem_rqst, mem_we, mem_addr,
        output mem_bits, mem_wdata
    );

    modport slave (
        output icache_rqst, icache_addr,
        output dr_rqst, dr_addr, dr_bits,
        output dw_rqst, dw_addr, dw_bits, dw_data,
        output mem_done, mem_rdata,
        input  icache_done, icache_data,
        input  dr_done, dr_data, dw_done,
        input  mem_rqst, mem_we, mem_addr,
        input  mem_bits, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache fetch, dcache read and dcache write.
// Define MEM_ARB_RR_EN for round-robin; default is fixed dw > dr > icache.
module mem_port_arbiter #(
    parameter int          AW      = 64,
    parameter int          DW      = 64,
    parameter logic [2:0]  IC_BITS = 3'd3
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [1:0] RIC = 2'd0;
    localparam logic [1:0] RDR = 2'd1;
    localparam logic [1:0] RDW = 2'd2;

    state_e        state_q, state_d;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    owner_q, owner_d;
    logic [AW-1:0] ic_addr_q, dr_addr_q, dw_addr_q;
    logic [2:0]    dr_bits_q, dw_bits_q;
    logic [DW-1:0] dw_data_q;

    logic          mem_rqst_q, mem_rqst_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]    mem_bits_q, mem_bits_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]    rqst, dup, acc, cand, gnt;
    logic          done_ok, issue;
    logic [AW-1:0] ic_addr_e, dr_addr_e, dw_addr_e;
    logic [2:0]    dr_bits_e, dw_bits_e;
    logic [DW-1:0] dw_data_e;

    function automatic logic [2:0] pick(
        input logic [2:0] c,
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] d
    );
        pick = '0;
        if (c[a])      pick[a] = 1'b1;
        else if (c[b]) pick[b] = 1'b1;
        else if (c[d]) pick[d] = 1'b1;
    endfunction

    assign rqst    = {bus.dw_rqst, bus.dr_rqst, bus.icache_rqst};
    assign done_ok = (state_q == BUSY) && bus.mem_done;
    // The owner may re-request in its own done cycle.
    assign dup     = rqst & (pend_q | (owner_q & {3{!done_ok}}));
    assign acc     = rqst & ~dup;
    assign cand    = pend_q | acc;
    assign issue   = ((state_q == IDLE) || done_ok) && (|cand);

    assign ic_addr_e = pend_q[RIC] ? ic_addr_q : bus.icache_addr;
    assign dr_addr_e = pend_q[RDR] ? dr_addr_q : bus.dr_addr;
    assign dr_bits_e = pend_q[RDR] ? dr_bits_q : bus.dr_bits;
    assign dw_addr_e = pend_q[RDW] ? dw_addr_q : bus.dw_addr;
    assign dw_bits_e = pend_q[RDW] ? dw_bits_q : bus.dw_bits;
    assign dw_data_e = pend_q[RDW] ? dw_data_q : bus.dw_data;

`ifdef MEM_ARB_RR_EN
    logic [2:0] last_q;

    always_comb begin
        gnt = '0;
        unique case (1'b1)
            last_q[RIC]: gnt = pick(cand, RDW, RDR, RIC);
            last_q[RDW]: gnt = pick(cand, RDR, RIC, RDW);
            default:     gnt = pick(cand, RIC, RDW, RDR);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)        last_q <= 3'b001;
        else if (issue) last_q <= gnt;
    end
`else
    assign gnt = pick(cand, RDW, RDR, RIC);
`endif

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q | acc;
        owner_d     = owner_q;
        mem_rqst_d  = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_bits_d  = mem_bits_q;
        mem_wdata_d = mem_wdata_q;
        if (issue) begin
            pend_d     = (pend_q | acc) & ~gnt;
            owner_d    = gnt;
            state_d    = BUSY;
            mem_rqst_d = 1'b1;
            unique case (1'b1)
                gnt[RDW]: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = dw_addr_e;
                    mem_bits_d  = dw_bits_e;
                    mem_wdata_d = dw_data_e;
                end
                gnt[RDR]: begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = dr_addr_e;
                    mem_bits_d = dr_bits_e;
                end
                gnt[RIC]: begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = ic_addr_e;
                    mem_bits_d = IC_BITS;
                end
                default: ;
            endcase
        end else if (done_ok) begin
            state_d = IDLE;
            owner_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            owner_q     <= '0;
            ic_addr_q   <= '0;
            dr_addr_q   <= '0;
            dr_bits_q   <= '0;
            dw_addr_q   <= '0;
            dw_bits_q   <= '0;
            dw_data_q   <= '0;
            mem_rqst_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_bits_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            owner_q     <= owner_d;
            mem_rqst_q  <= mem_rqst_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_bits_q  <= mem_bits_d;
            mem_wdata_q <= mem_wdata_d;
            if (acc[RIC]) ic_addr_q <= bus.icache_addr;
            if (acc[RDR]) begin
                dr_addr_q <= bus.dr_addr;
                dr_bits_q <= bus.dr_bits;
            end
            if (acc[RDW]) begin
                dw_addr_q <= bus.dw_addr;
                dw_bits_q <= bus.dw_bits;
                dw_data_q <= bus.dw_data;
            end
        end
    end

    assign bus.mem_rqst    = mem_rqst_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_bits    = mem_bits_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.icache_done = done_ok && owner_q[RIC] && !rst;
    assign bus.dr_done     = done_ok && owner_q[RDR] && !rst;
    assign bus.dw_done     = done_ok && owner_q[RDW] && !rst;
    assign bus.icache_data = bus.mem_rdata;
    assign bus.dr_data     = bus.mem_rdata;

`ifndef SYNTHESIS
    a_no_dup: assert property (@(posedge clk) disable iff (rst) dup == 3'b000)
        else $warning("mem_port_arbiter: duplicate request dropped %b", dup);
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, arbitration order,
// duplicate drop, reset mid-flight and dr/icache fairness.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .IC_BITS(3'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_run = 0;
    int n_fail = 0;
    int n_mrq = 0;
    int n_icd = 0;
    int n_drd = 0;

    always @(negedge clk) begin
        if (bus.mem_rqst)    n_mrq++;
        if (bus.icache_done) n_icd++;
        if (bus.dr_done)     n_drd++;
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.icache_rqst = 1'b0;
        bus.dr_rqst     = 1'b0;
        bus.dw_rqst     = 1'b0;
        bus.mem_done    = 1'b0;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic chk_issue(string tag, logic we, logic [63:0] a,
                             logic [2:0] b, logic [63:0] d, bit chk_d);
        obs();
        chk({tag, "_rqst"}, 64'(bus.mem_rqst), 64'd1);
        chk({tag, "_we"}, 64'(bus.mem_we), 64'(we));
        chk({tag, "_addr"}, bus.mem_addr, a);
        chk({tag, "_bits"}, 64'(bus.mem_bits), 64'(b));
        if (chk_d) chk({tag, "_wdata"}, bus.mem_wdata, d);
    endtask

    // who = {dw, dr, icache}
    task automatic finish_txn(string tag, logic [63:0] rd, logic [2:0] who);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = rd;
        obs();
        chk({tag, "_done"},
            64'({bus.dw_done, bus.dr_done, bus.icache_done}), 64'(who));
        chk({tag, "_norqst"}, 64'(bus.mem_rqst), 64'd0);
        if (who[0]) chk({tag, "_icdata"}, bus.icache_data, rd);
        if (who[1]) chk({tag, "_drdata"}, bus.dr_data, rd);
    endtask

    int c_mrq, c_icd, c_drd;

    initial begin
        rst = 1'b1;
        bus.icache_rqst = 1'b0; bus.icache_addr = '0;
        bus.dr_rqst = 1'b0; bus.dr_addr = '0; bus.dr_bits = '0;
        bus.dw_rqst = 1'b0; bus.dw_addr = '0; bus.dw_bits = '0;
        bus.dw_data = '0; bus.mem_done = 1'b0; bus.mem_rdata = '0;

        // reset held three cycles, mem_done pulsed inside it
        tick();
        tick();
        bus.mem_done = 1'b1;
        obs();
        chk("rst_done", 64'({bus.dw_done, bus.dr_done, bus.icache_done}), 64'd0);
        tick();
        obs();
        chk("rst_rqst_we", 64'({bus.mem_rqst, bus.mem_we}), 64'd0);
        chk("rst_addr", bus.mem_addr, 64'd0);
        chk("rst_bits", 64'(bus.mem_bits), 64'd0);
        chk("rst_wdata", bus.mem_wdata, 64'd0);
        chk("rst_data", bus.icache_data | bus.dr_data, 64'd0);
        rst = 1'b0;
        tick();
        bus.mem_done = 1'b1;
        obs();
        chk("idle_done", 64'({bus.dw_done, bus.dr_done, bus.icache_done}), 64'd0);
        tick();
        obs();
        chk("idle_norqst", 64'(bus.mem_rqst), 64'd0);

        // single fetch
        tick();
        bus.icache_rqst = 1'b1;
        bus.icache_addr = 64'h400000;
        tick();
        chk_issue("fetch", 1'b0, 64'h400000, 3'd3, 64'd0, 1'b0);
        tick();
        obs();
        chk("fetch_1cyc", 64'(bus.mem_rqst), 64'd0);
        tick();
        finish_txn("fetch", 64'h00000013_00000013, 3'b001);
        tick();
        obs();
        chk("fetch_idle", 64'({bus.mem_rqst, bus.icache_done}), 64'd0);

        // simultaneous requests: dw, dr, icache
        tick();
        bus.icache_rqst = 1'b1; bus.icache_addr = 64'h400008;
        bus.dr_rqst = 1'b1; bus.dr_addr = 64'h1000; bus.dr_bits = 3'd2;
        bus.dw_rqst = 1'b1; bus.dw_addr = 64'h2000; bus.dw_bits = 3'd3;
        bus.dw_data = 64'hDEAD;
        tick();
        chk_issue("sim_dw", 1'b1, 64'h2000, 3'd3, 64'hDEAD, 1'b1);
        tick();
        finish_txn("sim_dw", 64'd0, 3'b100);
        tick();
        chk_issue("sim_dr", 1'b0, 64'h1000, 3'd2, 64'd0, 1'b0);
        tick();
        finish_txn("sim_dr", 64'h1111, 3'b010);
        tick();
        chk_issue("sim_ic", 1'b0, 64'h400008, 3'd3, 64'd0, 1'b0);
        tick();
        finish_txn("sim_ic", 64'h2222, 3'b001);
        tick();
        obs();
        chk("sim_idle", 64'(bus.mem_rqst), 64'd0);

        // duplicate icache request while in flight
        tick();
        c_mrq = n_mrq;
        c_icd = n_icd;
        bus.icache_rqst = 1'b1;
        bus.icache_addr = 64'h400010;
        tick();
        bus.icache_rqst = 1'b1;
        chk_issue("dup", 1'b0, 64'h400010, 3'd3, 64'd0, 1'b0);
        tick();
        tick();
        finish_txn("dup", 64'h33, 3'b001);
        tick();
        tick();
        tick();
        chk("dup_nrqst", 64'(n_mrq - c_mrq), 64'd1);
        chk("dup_ndone", 64'(n_icd - c_icd), 64'd1);

        // reset while a read is in flight
        c_drd = n_drd;
        bus.dr_rqst = 1'b1;
        bus.dr_addr = 64'h3000;
        bus.dr_bits = 3'd1;
        tick();
        chk_issue("rmf", 1'b0, 64'h3000, 3'd1, 64'd0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_rdata = 64'h44;
        obs();
        chk("rmf_nodone", 64'(bus.dr_done), 64'd0);
        chk("rmf_norqst", 64'(bus.mem_rqst), 64'd0);
        tick();
        bus.dw_rqst = 1'b1; bus.dw_addr = 64'h4000;
        bus.dw_bits = 3'd3; bus.dw_data = 64'hBEEF;
        tick();
        chk_issue("rmf_next", 1'b1, 64'h4000, 3'd3, 64'hBEEF, 1'b1);
        tick();
        finish_txn("rmf_next", 64'd0, 3'b100);
        chk("rmf_ndr", 64'(n_drd - c_drd), 64'd0);

        // dr re-requests in its done cycle while icache waits
        tick();
        bus.dr_rqst = 1'b1; bus.dr_addr = 64'h5000; bus.dr_bits = 3'd3;
        bus.icache_rqst = 1'b1; bus.icache_addr = 64'h400020;
        tick();
        chk_issue("stv_dr1", 1'b0, 64'h5000, 3'd3, 64'd0, 1'b0);
        tick();
        bus.dr_rqst = 1'b1; bus.dr_addr = 64'h5008;
        finish_txn("stv_dr1", 64'h55, 3'b010);
        tick();
`ifdef MEM_ARB_RR_EN
        chk_issue("stv_ic", 1'b0, 64'h400020, 3'd3, 64'd0, 1'b0);
        tick();
        finish_txn("stv_ic", 64'h66, 3'b001);
        tick();
        chk_issue("stv_dr2", 1'b0, 64'h5008, 3'd3, 64'd0, 1'b0);
        tick();
        finish_txn("stv_dr2", 64'h77, 3'b010);
`else
        chk_issue("stv_dr2", 1'b0, 64'h5008, 3'd3, 64'd0, 1'b0);
        tick();
        finish_txn("stv_dr2", 64'h77, 3'b010);
        tick();
        chk_issue("stv_ic", 1'b0, 64'h400020, 3'd3, 64'd0, 1'b0);
        tick();
        finish_txn("stv_ic", 64'h66, 3'b001);
`endif
        tick();
        obs();
        chk("end_idle", 64'(bus.mem_rqst), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
